// File: rtl/reg_file_scoreboard_pkg.sv
// Shared types and sizes for the register-file scoreboard: register index type,
// the hard-wired zero register and the default outstanding-write counter width.
package reg_file_scoreboard_pkg;

    localparam int NUM_REGS = 32;
    localparam int SB_CNT_W = 2;

    typedef logic [4:0] reg_idx_t;
    localparam reg_idx_t REGISTER_X0 = 5'd0;

    typedef logic [SB_CNT_W-1:0] scoreboard_cnt_t;

endpackage

// File: rtl/reg_file_scoreboard_counter.sv
// Saturating up/down counter of outstanding writes for one architectural register.
// Flush clears synchronously; a simultaneous inc and dec cancel out.
module reg_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max,
    output logic             nonzero
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign at_max  = &cnt_reg;
    assign nonzero = |cnt_reg;
    assign cnt     = cnt_reg;

    // Guards against wrap in both directions even if a caller misbehaves.
    always_comb begin
        cnt_next = cnt_reg;
        if (flush) begin
            cnt_next = '0;
        end else if (inc && !dec && !at_max) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else if (dec && !inc && nonzero) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Issue-gating scoreboard: counts in-flight writes per register, stalls RAW hazards and
// counter saturation, releases on writeback and clears everything on flush.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int CNT_W     = SB_CNT_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rs1,
    input  logic [4:0]          issue_rs2,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    input  logic [4:0]          issue_rd,
    input  logic                issue_wr_rd,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err_underflow
);

    reg_idx_t rs1_idx;
    reg_idx_t rs2_idx;
    reg_idx_t rd_idx;
    reg_idx_t wb_idx;

    assign rs1_idx = issue_rs1;
    assign rs2_idx = issue_rs2;
    assign rd_idx  = issue_rd;
    assign wb_idx  = wb_rd;

    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] nonzero_vec;
    logic [NUM_REGS-1:0] at_max_vec;
    logic [NUM_REGS-1:0] bypass_vec;

    logic fire;
    logic hz_rs1;
    logic hz_rs2;
    logic rd_full;
    logic err_underflow_reg;

    assign fire = issue_valid & issue_ready;

    // x0 has no counter: it can never be busy, full or bypassed.
    assign inc_vec[0]     = 1'b0;
    assign dec_vec[0]     = 1'b0;
    assign nonzero_vec[0] = 1'b0;
    assign at_max_vec[0]  = 1'b0;
    assign bypass_vec[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt;
            logic             wb_hit;

            assign wb_hit          = wb_valid && (wb_idx == reg_idx_t'(gi));
            assign inc_vec[gi]     = fire && issue_wr_rd && (rd_idx == reg_idx_t'(gi));
            assign dec_vec[gi]     = wb_hit && nonzero_vec[gi];
            // Writeback retiring the last pending write makes the value available this cycle.
            assign bypass_vec[gi]  = WB_BYPASS && wb_hit && (cnt == CNT_W'(1));

            reg_sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush   (flush),
                .inc     (inc_vec[gi]),
                .dec     (dec_vec[gi]),
                .cnt     (cnt),
                .at_max  (at_max_vec[gi]),
                .nonzero (nonzero_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        hz_rs1  = (rs1_idx != REGISTER_X0) && nonzero_vec[rs1_idx] && !bypass_vec[rs1_idx];
        hz_rs2  = (rs2_idx != REGISTER_X0) && nonzero_vec[rs2_idx] && !bypass_vec[rs2_idx];
        rd_full = at_max_vec[rd_idx];
        issue_ready = !(issue_use_rs1 && hz_rs1)
                   && !(issue_use_rs2 && hz_rs2)
                   && !(issue_wr_rd && rd_full);
    end

    // A writeback squashed by flush is ignored, so it cannot raise the error either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow_reg <= 1'b0;
        end else if (!flush && wb_valid && (wb_idx != REGISTER_X0) && !nonzero_vec[wb_idx]) begin
            err_underflow_reg <= 1'b1;
        end
    end

    assign busy_vec      = nonzero_vec;
    assign err_underflow = err_underflow_reg;

endmodule
